// File: rtl/mux_n_stream_pkg.sv
// Shared types and helpers for the N-way stream multiplexer.
// Imported by the interface, the arbiter and the top level.
package mux_pkg;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    // Index width; never narrower than one bit, even for a single channel.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_stream_if.sv
// Request/response bundle of mux_n_stream: NUM_IN valid/ready inputs merged into one output.
// master drives the requests and out_ready, slave is the multiplexer.
interface mux_n_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_IN     = 4
) ();
    localparam int unsigned SEL_W = mux_pkg::sel_width(NUM_IN);

    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]             out_sel;
    logic                         out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux_n_stream_arbiter.sv
// One-hot arbiter for mux_n_stream: round-robin by default, fixed lowest-index priority
// when MUX_N_STREAM_FIXED_PRIO_EN is defined.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned  NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

`ifdef MUX_N_STREAM_FIXED_PRIO_EN

    // No pointer state in this build; keep the port list identical.
    logic unused_ports;
    assign unused_ports = clk ^ rst_n ^ advance;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

`else

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    // Search starts just above the last winner and wraps.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = SEL_W'((int'(rr_ptr_q) + k) % NUM_IN);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer only moves on a real transfer so idle cycles keep fairness.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SEL_W'(NUM_IN - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`endif

endmodule

// File: rtl/mux_n_stream.sv
// N-way valid/ready stream multiplexer with a registered output slot (1-cycle latency,
// full throughput). MUX_N_STREAM_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mux_n_stream
    import mux_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  NUM_IN     = 4,
    localparam int unsigned SEL_W      = sel_width(NUM_IN)
) (
    input logic            clk,
    input logic            rst_n,
    mux_n_stream_if.slave  bus
);

    slot_state_e           slot_q, slot_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]      sel_q, sel_d;

    logic                  load;
    logic                  transfer;
    logic [NUM_IN-1:0]     grant;
    logic [SEL_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;

    // Nothing is accepted while reset is asserted, even if the slot looks empty.
    assign load         = rst_n & ((slot_q == SLOT_EMPTY) | bus.out_ready);
    assign bus.in_ready = grant & {NUM_IN{load}};
    assign transfer     = |(bus.in_valid & bus.in_ready);

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.in_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        sel_d  = sel_q;
        unique case (slot_q)
            SLOT_EMPTY: begin
                if (transfer) begin
                    slot_d = SLOT_FULL;
                    data_d = grant_data;
                    sel_d  = grant_idx;
                end
            end
            SLOT_FULL: begin
                // Old beat leaves and a new one loads on the same edge when possible.
                if (bus.out_ready) begin
                    if (transfer) begin
                        data_d = grant_data;
                        sel_d  = grant_idx;
                    end else begin
                        slot_d = SLOT_EMPTY;
                    end
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

    assign bus.out_valid = (slot_q == SLOT_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule
